// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller between the IF/MEM stages and a
// single 8-bit synchronous RAM port. Data accesses win arbitration over
// instruction fetches. Each access is split into 1, 2 or 4 little-endian
// byte transfers. Loads are reassembled and optionally sign-extended, and
// the owner gets a one-cycle done pulse.
//
// Ports
//   clk, rst        system clock (rising edge), async active-high reset
//   if_req/if_addr  fetch request (always a 4-byte read)
//   if_done/if_inst fetch done pulse and fetched word
//   mem_*           data request: we, addr, size, sext, wdata
//   mem_done        data done pulse, mem_rdata valid for loads
//   ram_addr/din/wr RAM byte address, write data, write enable
//   ram_dout        RAM read data, one cycle after its address
//   busy            controller not idle
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | sample requests; accept data first, then fetch
// ST_READ  | present byte addresses, capture ram_dout one cycle later
// ST_WRITE | present one byte per cycle with ram_wr high
// ST_DONE  | owner's done is high; requests are not sampled here
module mem_ctrl #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [31:0]       if_inst,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [1:0]        mem_size,
   input  logic              mem_sext,
   input  logic [31:0]       mem_wdata,
   output logic              mem_done,
   output logic [31:0]       mem_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_din,
   output logic              ram_wr,
   input  logic [7:0]        ram_dout,
   output logic              busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          cnt_q, cnt_d;
   logic [1:0]          lst_q, lst_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                sext_q, sext_d;
   logic                own_q, own_d;
   logic [31:0]         rbuf_q, rbuf_d;

   logic                if_done_q, if_done_d;
   logic [31:0]         if_inst_q, if_inst_d;
   logic                mem_done_q, mem_done_d;
   logic [31:0]         mem_rdata_q, mem_rdata_d;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic [7:0]          ram_din_q, ram_din_d;
   logic                ram_wr_q, ram_wr_d;
   logic                busy_q, busy_d;

   logic [2:0]          cnt_nx;
   logic [1:0]          bidx;
   logic [31:0]         asm_v;
   logic [31:0]         ext_v;

   // size code to index of the last byte: 0 -> byte, 1 -> half, 2/3 -> word
   function automatic logic [1:0] last_idx(input logic [1:0] size);
      case (size)
         2'b00:   last_idx = 2'd0;
         2'b01:   last_idx = 2'd1;
         default: last_idx = 2'd3;
      endcase
   endfunction

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      lst_d       = lst_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      sext_d      = sext_q;
      own_d       = own_q;
      rbuf_d      = rbuf_q;
      if_done_d   = 1'b0;
      if_inst_d   = if_inst_q;
      mem_done_d  = 1'b0;
      mem_rdata_d = mem_rdata_q;
      ram_addr_d  = ram_addr_q;
      ram_din_d   = ram_din_q;
      ram_wr_d    = 1'b0;
      cnt_nx      = cnt_q + 3'd1;
      bidx        = cnt_q[1:0] - 2'd1;
      asm_v       = rbuf_q;
      ext_v       = rbuf_q;

      case (state_q)
         ST_IDLE: begin
            if (mem_req) begin
               addr_d     = mem_addr;
               wdata_d    = mem_wdata;
               lst_d      = last_idx(mem_size);
               sext_d     = mem_sext & ~mem_we;
               own_d      = 1'b1;
               cnt_d      = 3'd0;
               rbuf_d     = 32'd0;
               ram_addr_d = mem_addr;
               if (mem_we) begin
                  ram_din_d = mem_wdata[7:0];
                  ram_wr_d  = 1'b1;
                  state_d   = ST_WRITE;
               end else begin
                  state_d   = ST_READ;
               end
            end else if (if_req) begin
               addr_d     = if_addr;
               lst_d      = 2'd3;
               sext_d     = 1'b0;
               own_d      = 1'b0;
               cnt_d      = 3'd0;
               rbuf_d     = 32'd0;
               ram_addr_d = if_addr;
               state_d    = ST_READ;
            end
         end

         ST_WRITE: begin
            if (cnt_q[1:0] == lst_q) begin
               ram_addr_d = '0;
               mem_done_d = own_q;
               if_done_d  = ~own_q;
               state_d    = ST_DONE;
            end else begin
               cnt_d      = cnt_nx;
               ram_addr_d = addr_q + ADDR_W'(cnt_nx);
               ram_din_d  = wdata_q[{cnt_nx[1:0], 3'b000} +: 8];
               ram_wr_d   = 1'b1;
            end
         end

         ST_READ: begin
            // cnt_q counts edges since accept; byte cnt_q-1 is on ram_dout now
            if (cnt_q != 3'd0)
               asm_v[{bidx, 3'b000} +: 8] = ram_dout;
            rbuf_d = asm_v;
            if (cnt_q == {1'b0, lst_q} + 3'd1) begin
               ext_v = asm_v;
               if (lst_q == 2'd0)
                  ext_v[31:8] = {24{sext_q & asm_v[7]}};
               else if (lst_q == 2'd1)
                  ext_v[31:16] = {16{sext_q & asm_v[15]}};
               if (own_q) begin
                  mem_rdata_d = ext_v;
                  mem_done_d  = 1'b1;
               end else begin
                  if_inst_d   = ext_v;
                  if_done_d   = 1'b1;
               end
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_nx;
               if (cnt_q < {1'b0, lst_q})
                  ram_addr_d = addr_q + ADDR_W'(cnt_nx);
               else
                  ram_addr_d = '0;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 3'd0;
         lst_q       <= 2'd0;
         addr_q      <= '0;
         wdata_q     <= 32'd0;
         sext_q      <= 1'b0;
         own_q       <= 1'b0;
         rbuf_q      <= 32'd0;
         if_done_q   <= 1'b0;
         if_inst_q   <= 32'd0;
         mem_done_q  <= 1'b0;
         mem_rdata_q <= 32'd0;
         ram_addr_q  <= '0;
         ram_din_q   <= 8'd0;
         ram_wr_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         lst_q       <= lst_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         sext_q      <= sext_d;
         own_q       <= own_d;
         rbuf_q      <= rbuf_d;
         if_done_q   <= if_done_d;
         if_inst_q   <= if_inst_d;
         mem_done_q  <= mem_done_d;
         mem_rdata_q <= mem_rdata_d;
         ram_addr_q  <= ram_addr_d;
         ram_din_q   <= ram_din_d;
         ram_wr_q    <= ram_wr_d;
         busy_q      <= busy_d;
      end
   end

   assign if_done   = if_done_q;
   assign if_inst   = if_inst_q;
   assign mem_done  = mem_done_q;
   assign mem_rdata = mem_rdata_q;
   assign ram_addr  = ram_addr_q;
   assign ram_din   = ram_din_q;
   assign ram_wr    = ram_wr_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_done;
   logic [31:0] if_inst;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [1:0]  mem_size;
   logic        mem_sext;
   logic [31:0] mem_wdata;
   logic        mem_done;
   logic [31:0] mem_rdata;
   logic [31:0] ram_addr;
   logic [7:0]  ram_din;
   logic        ram_wr;
   logic [7:0]  ram_dout;
   logic        busy;

   int n_tests;
   int n_fail;

   logic [7:0] ram [0:4095];

   mem_ctrl #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_size(mem_size),
      .mem_sext(mem_sext), .mem_wdata(mem_wdata), .mem_done(mem_done),
      .mem_rdata(mem_rdata), .ram_addr(ram_addr), .ram_din(ram_din),
      .ram_wr(ram_wr), .ram_dout(ram_dout), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // synchronous RAM model, 4 KiB aliased over the full address space
   always @(posedge clk) begin
      if (ram_wr) ram[ram_addr[11:0]] <= ram_din;
      ram_dout <= ram[ram_addr[11:0]];
   end

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [1:0]  size;
      logic        sext;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      int          exp_lat;
   } vec_t;

   vec_t vecs [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // one data access; returns latency (edges from accept to done) and ram_addr per edge
   task automatic do_mem(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic sext, input logic [31:0] wdata,
                         output logic [31:0] rdata, output int lat,
                         output logic [31:0] atr [4]);
      @(negedge clk);
      mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_size = size;
      mem_sext = sext; mem_wdata = wdata;
      @(posedge clk); #1;
      atr[0] = ram_addr;
      mem_req = 1'b0;
      mem_wdata = 32'h5555_5555;
      mem_addr = 32'h0;
      lat = 0;
      while (!mem_done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (lat < 4) atr[lat] = ram_addr;
      end
      rdata = mem_rdata;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] last_load;
      logic [31:0] atr [4];
      int          lat;
      int          cnt;
      int          pulses;

      n_tests = 0; n_fail = 0;
      for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
      if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_addr = 0;
      mem_size = 0; mem_sext = 0; mem_wdata = 0;
      for (int i = 0; i < 4; i++) atr[i] = 32'h0;

      //            we    addr          size   sext  wdata          exp_rdata      lat
      vecs[0]  = '{1'b1, 32'h0000_0200, 2'b10, 1'b0, 32'h1122_3344, 32'h0,        4};
      vecs[1]  = '{1'b0, 32'h0000_0200, 2'b10, 1'b0, 32'h0,        32'h1122_3344, 5};
      vecs[2]  = '{1'b1, 32'h0000_0300, 2'b00, 1'b0, 32'hDEAD_BE80, 32'h0,        1};
      vecs[3]  = '{1'b0, 32'h0000_0300, 2'b00, 1'b1, 32'h0,        32'hFFFF_FF80, 2};
      vecs[4]  = '{1'b0, 32'h0000_0300, 2'b00, 1'b0, 32'h0,        32'h0000_0080, 2};
      vecs[5]  = '{1'b1, 32'h0000_0301, 2'b01, 1'b1, 32'h1234_8001, 32'h0,        2};
      vecs[6]  = '{1'b0, 32'h0000_0301, 2'b01, 1'b1, 32'h0,        32'hFFFF_8001, 3};
      vecs[7]  = '{1'b0, 32'h0000_0301, 2'b01, 1'b0, 32'h0,        32'h0000_8001, 3};
      vecs[8]  = '{1'b0, 32'h0000_0300, 2'b10, 1'b0, 32'h0,        32'h0080_0180, 5};
      vecs[9]  = '{1'b1, 32'h0000_0401, 2'b10, 1'b0, 32'hCAFE_F00D, 32'h0,        4};
      vecs[10] = '{1'b0, 32'h0000_0403, 2'b01, 1'b1, 32'h0,        32'hFFFF_CAFE, 3};
      vecs[11] = '{1'b0, 32'h0000_0402, 2'b00, 1'b1, 32'h0,        32'hFFFF_FFF0, 2};
      vecs[12] = '{1'b1, 32'h0000_0500, 2'b11, 1'b0, 32'hA5A5_5A5A, 32'h0,        4};
      vecs[13] = '{1'b0, 32'h0000_0500, 2'b11, 1'b1, 32'h0,        32'hA5A5_5A5A, 5};
      vecs[14] = '{1'b0, 32'h0000_0203, 2'b00, 1'b1, 32'h0,        32'h0000_0011, 2};
      vecs[15] = '{1'b1, 32'h0000_0203, 2'b00, 1'b1, 32'h0000_00EE, 32'h0,        1};

      // reset
      rst = 1'b1;
      #12;
      check("rst if_done",   {31'd0, if_done},  32'd0);
      check("rst mem_done",  {31'd0, mem_done}, 32'd0);
      check("rst busy",      {31'd0, busy},     32'd0);
      check("rst ram_wr",    {31'd0, ram_wr},   32'd0);
      check("rst ram_addr",  ram_addr,          32'd0);
      check("rst ram_din",   {24'd0, ram_din},  32'd0);
      check("rst if_inst",   if_inst,           32'd0);
      check("rst mem_rdata", mem_rdata,         32'd0);
      @(negedge clk); rst = 1'b0;

      // byte store trace
      @(negedge clk);
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h100; mem_size = 2'b00; mem_wdata = 32'hDEADBEEF;
      @(posedge clk); #1;
      mem_req = 1'b0;
      check("bst wr@A",    {31'd0, ram_wr},   32'd1);
      check("bst addr@A",  ram_addr,          32'h100);
      check("bst din@A",   {24'd0, ram_din},  32'hEF);
      check("bst done@A",  {31'd0, mem_done}, 32'd0);
      check("bst busy@A",  {31'd1 & 31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      check("bst done@A1", {31'd0, mem_done}, 32'd1);
      check("bst wr@A1",   {31'd0, ram_wr},   32'd0);
      check("bst addr@A1", ram_addr,          32'h0);
      @(posedge clk); #1;
      check("bst done@A2", {31'd0, mem_done}, 32'd0);
      check("bst busy@A2", {31'd0, busy},     32'd0);
      check("bst ram",     {24'd0, ram[12'h100]}, 32'hEF);

      // table-driven accesses
      last_load = 32'h0;
      for (int i = 0; i < 16; i++) begin
         do_mem(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].sext, vecs[i].wdata, rd, lat, atr);
         check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
         if (vecs[i].we) begin
            check($sformatf("vec%0d rdata kept", i), rd, last_load);
         end else begin
            check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            last_load = vecs[i].exp_rdata;
         end
      end
      check("word store bytes", {ram[12'h203], ram[12'h202], ram[12'h201], ram[12'h200]}, 32'hEE22_3344);

      // arbitration: data and fetch requested together
      @(negedge clk);
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h300; mem_size = 2'b00; mem_sext = 1'b0;
      if_req = 1'b1; if_addr = 32'h400;
      @(posedge clk); #1;
      mem_req = 1'b0;
      cnt = 0; pulses = 0;
      while (!mem_done && cnt < 20) begin
         @(posedge clk); #1;
         cnt++;
         if (if_done) pulses++;
      end
      check("arb data lat",   cnt, 2);
      check("arb data rdata", mem_rdata, 32'h0000_0080);
      @(posedge clk); #1;
      check("arb no accept at DONE->IDLE", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      check("arb fetch accepted", {31'd0, busy}, 32'd1);
      if_req = 1'b0; if_addr = 32'h0;
      cnt = 0;
      while (!if_done && cnt < 20) begin
         @(posedge clk); #1;
         cnt++;
      end
      check("arb fetch lat", cnt, 5);
      check("arb if_inst",   if_inst, 32'hFEF0_0D00);
      check("arb mem_rdata kept", mem_rdata, 32'h0000_0080);
      pulses++;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (if_done) pulses++;
      end
      check("arb if_done pulses", pulses, 1);

      // address wrap, store then load
      do_mem(1'b1, 32'hFFFF_FFFE, 2'b10, 1'b0, 32'h4433_2211, rd, lat, atr);
      check("wrap st addr0", atr[0], 32'hFFFF_FFFE);
      check("wrap st addr1", atr[1], 32'hFFFF_FFFF);
      check("wrap st addr2", atr[2], 32'h0000_0000);
      check("wrap st addr3", atr[3], 32'h0000_0001);
      do_mem(1'b0, 32'hFFFF_FFFE, 2'b10, 1'b0, 32'h0, rd, lat, atr);
      check("wrap ld addr0", atr[0], 32'hFFFF_FFFE);
      check("wrap ld addr1", atr[1], 32'hFFFF_FFFF);
      check("wrap ld addr2", atr[2], 32'h0000_0000);
      check("wrap ld addr3", atr[3], 32'h0000_0001);
      check("wrap ld rdata", rd, 32'h4433_2211);
      check("wrap ld lat",   lat, 5);

      // reset in the middle of a word store
      @(negedge clk);
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h600; mem_size = 2'b10; mem_wdata = 32'h9988_7766;
      @(posedge clk); #1;
      mem_req = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rmid addr before rst", ram_addr, 32'h602);
      #2 rst = 1'b1;
      #1;
      check("rmid busy",      {31'd0, busy},     32'd0);
      check("rmid ram_wr",    {31'd0, ram_wr},   32'd0);
      check("rmid ram_addr",  ram_addr,          32'd0);
      check("rmid ram_din",   {24'd0, ram_din},  32'd0);
      check("rmid mem_rdata", mem_rdata,         32'd0);
      check("rmid if_inst",   if_inst,           32'd0);
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (mem_done) pulses++;
      end
      check("rmid no done", pulses, 0);
      check("rmid bytes kept", {ram[12'h602], ram[12'h601], ram[12'h600]}, 32'h0000_7766);
      @(negedge clk); rst = 1'b0;
      do_mem(1'b0, 32'h601, 2'b00, 1'b0, 32'h0, rd, lat, atr);
      check("post-rst load",  rd, 32'h0000_0077);
      check("post-rst lat",   lat, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller sitting directly downstream of the MEM stage and the IF stage.
- Accepts 32-bit instruction fetches and sized data loads/stores.
- Arbitrates between the two requesters, with data having priority.
- Serialises each access onto a single 8-bit synchronous RAM port, little-endian.
- Returns assembled, optionally sign-extended read data with a one-cycle done pulse.

Parameters:
ADDR_W, 32, width of RAM byte address; all address arithmetic is modulo 2^ADDR_W.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
if_req  in  1  instruction fetch request (always a 4-byte read)
if_addr  in  ADDR_W  fetch byte address
if_done  out  1  one-cycle pulse: if_inst valid
if_inst  out  32  fetched instruction
mem_req  in  1  data access request
mem_we  in  1  1 = store, 0 = load
mem_addr  in  ADDR_W  data byte address (unaligned allowed)
mem_size  in  2  00 byte, 01 half, 10/11 word
mem_sext  in  1  loads only: 1 sign-extend, 0 zero-extend
mem_wdata  in  32  store data; low bytes used per size
mem_done  out  1  one-cycle pulse: access complete, mem_rdata valid for loads
mem_rdata  out  32  load result
ram_addr  out  ADDR_W  RAM byte address
ram_din  out  8  RAM write data
ram_wr  out  1  RAM write enable
ram_dout  in  8  RAM read data, valid the cycle after its address is presented
busy  out  1  state != IDLE

Behaviour:
- All outputs are registered.
- Reset values: if_done 0, mem_done 0, if_inst 0, mem_rdata 0, ram_addr 0, ram_din 0, ram_wr 0, busy 0; state IDLE; byte counter 0.
- States:
  - IDLE: samples requests at each rising edge.
    - mem_req=1 wins over if_req; the other requester waits.
    - Accepting latches addr, we, size (N = 1/2/4 bytes; fetch N = 4), sext, wdata, and owner; then goes to READ or WRITE.
  - WRITE: after accept edge A+i (i = 0..N-1), drive ram_addr = addr+i, ram_din = wdata byte i, ram_wr = 1.
    - At edge A+N: ram_wr = 0, ram_addr = 0, done of owner = 1, go to DONE.
  - READ: after edge A+i (i = 0..N-1), drive ram_addr = addr+i, ram_wr = 0.
    - Byte i is captured from ram_dout at edge A+2+i into bits [8i+7:8i].
    - At edge A+N+1 the last byte is captured and extension applied. Result goes to if_inst or mem_rdata. Done of owner = 1; go to DONE.
  - DONE: lasts exactly one cycle (done high). At the next edge: done = 0, go to IDLE.
    - Requests are not sampled at the DONE→IDLE edge. The earliest next accept is one edge later, which lets the requester drop or change its request.
- Latency from accept edge to done high: word load 5, half load 3, byte load 2, word store 4, half store 2, byte store 1. Fetch = word load.
- Extension:
  - Byte: bits 31:8 = sext ? bit7 : 0.
  - Half: bits 31:16 = sext ? bit15 : 0.
  - Word: no extension.
  - mem_sext is ignored for stores and fetches.
- Address wrap: addr+i wraps modulo 2^ADDR_W; no alignment check.
- Read-data retention: if_inst and mem_rdata hold their value until overwritten by the next completed read of the same owner. Stores do not modify mem_rdata.
- Request changes after the accept edge are ignored; latched operands are used.
- Reset mid-operation:
  - Immediate return to reset values, no done pulse.
  - Bytes already written stay written; no rollback.
- Simultaneous if_req and mem_req in IDLE: the data access is served first. The fetch is accepted at the first IDLE edge after the data access, if still asserted.

Test Plan:
- Reset then byte store at 0x100, wdata 0xDEADBEEF → one cycle ram_wr=1, addr 0x100, din 0xEF; mem_done high 1 cycle after accept edge.
- Word store 0x11223344 at 0x200, then word load 0x200 (RAM model) → write bytes 44,33,22,11 at 0x200..0x203; load mem_rdata 0x11223344, mem_done 5 cycles after accept.
- Byte load from address holding 0x80: sext=1 → 0xFFFFFF80; sext=0 → 0x00000080. Half load 0x8001 with sext=1 → 0xFFFF8001.
- if_req and mem_req both high at an IDLE edge → data served first, with mem_done pulse. if_req held → fetch accepted two edges after mem_done rises; if_inst correct; if_done pulses exactly once.
- Word load at address 2^ADDR_W−2 → ram_addr sequence FFFF_FFFE, FFFF_FFFF, 0, 1 (ADDR_W = 32).
- rst asserted asynchronously after 2 bytes of a word store → outputs immediately at reset values, busy 0, no mem_done. Next request is accepted normally after rst is released.
